// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the data-memory port: CPU (port 0) and debug/loader (port 1).
// Define DMEM_ARB_CPU_PRIORITY_EN for fixed CPU priority instead of round-robin arbitration.
module dmem_arbiter #(
    parameter int DBITS       = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_p0_req,
    input  logic             i_p0_wr,
    input  logic [DBITS-1:0] i_p0_addr,
    input  logic [DBITS-1:0] i_p0_wdata,
    input  logic             i_p1_req,
    input  logic             i_p1_wr,
    input  logic [DBITS-1:0] i_p1_addr,
    input  logic [DBITS-1:0] i_p1_wdata,
    output logic             o_p0_ack,
    output logic             o_p0_err,
    output logic [DBITS-1:0] o_p0_rdata,
    output logic             o_p1_ack,
    output logic             o_p1_err,
    output logic [DBITS-1:0] o_p1_rdata,
    output logic             o_cpu_stall,
    output logic             o_mem_en,
    output logic             o_mem_wr,
    output logic [DBITS-1:0] o_mem_addr,
    output logic [DBITS-1:0] o_mem_wdata,
    input  logic [DBITS-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t           r_state, w_next;
    logic             r_gnt, r_wr, r_err;
    logic [DBITS-1:0] r_addr, r_wdata, r_rdata;
    logic [3:0]       r_cnt;

    logic             w_any, w_sel, w_sel_wr, w_misalign, w_done;
    logic [DBITS-1:0] w_sel_addr, w_sel_wdata;

`ifdef DMEM_ARB_CPU_PRIORITY_EN
    assign w_sel = ~i_p0_req;
`else
    logic r_last;
    // On a contest the port that was not granted last wins.
    assign w_sel = (i_p0_req & i_p1_req) ? ~r_last : i_p1_req;
`endif

    assign w_any       = i_p0_req | i_p1_req;
    assign w_sel_wr    = w_sel ? i_p1_wr    : i_p0_wr;
    assign w_sel_addr  = w_sel ? i_p1_addr  : i_p0_addr;
    assign w_sel_wdata = w_sel ? i_p1_wdata : i_p0_wdata;
    assign w_misalign  = |w_sel_addr[1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = w_misalign ? S_DONE : S_ISSUE;
            S_ISSUE: w_next = r_wr ? S_DONE : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd1) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_gnt   <= 1'b0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
            r_last  <= 1'b1;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_gnt   <= w_sel;
                    r_wr    <= w_sel_wr;
                    r_addr  <= w_sel_addr;
                    r_wdata <= w_sel_wdata;
                    r_err   <= w_misalign;
                    r_rdata <= '0;
                end
                S_ISSUE: r_cnt <= 4'(MEM_LATENCY);
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_rdata <= i_mem_rdata;
                end
                S_DONE: begin
`ifndef DMEM_ARB_CPU_PRIORITY_EN
                    r_last <= r_gnt;
`endif
                end
                default: ;
            endcase
        end
    end

    // Memory fields are forced to zero outside the issue cycle.
    assign w_done      = (r_state == S_DONE);
    assign o_mem_en    = (r_state == S_ISSUE);
    assign o_mem_wr    = o_mem_en & r_wr;
    assign o_mem_addr  = o_mem_en ? r_addr  : '0;
    assign o_mem_wdata = o_mem_en ? r_wdata : '0;

    assign o_p0_ack    = w_done & ~r_gnt;
    assign o_p1_ack    = w_done & r_gnt;
    assign o_p0_err    = o_p0_ack & r_err;
    assign o_p1_err    = o_p1_ack & r_err;
    assign o_p0_rdata  = o_p0_ack ? r_rdata : '0;
    assign o_p1_rdata  = o_p1_ack ? r_rdata : '0;
    assign o_cpu_stall = i_p0_req & ~o_p0_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-timing reference model checked every cycle,
// directed scenarios with literal expectations, then randomized requesters.
module tb_dmem_arbiter;
    localparam int DB  = 32;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_p0_req, i_p0_wr, i_p1_req, i_p1_wr;
    logic [DB-1:0] i_p0_addr, i_p0_wdata, i_p1_addr, i_p1_wdata;
    logic          o_p0_ack, o_p0_err, o_p1_ack, o_p1_err, o_cpu_stall;
    logic [DB-1:0] o_p0_rdata, o_p1_rdata;
    logic          o_mem_en, o_mem_wr;
    logic [DB-1:0] o_mem_addr, o_mem_wdata, i_mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.DBITS(DB), .MEM_LATENCY(LAT)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_p0_req(i_p0_req), .i_p0_wr(i_p0_wr), .i_p0_addr(i_p0_addr), .i_p0_wdata(i_p0_wdata),
        .i_p1_req(i_p1_req), .i_p1_wr(i_p1_wr), .i_p1_addr(i_p1_addr), .i_p1_wdata(i_p1_wdata),
        .o_p0_ack(o_p0_ack), .o_p0_err(o_p0_err), .o_p0_rdata(o_p0_rdata),
        .o_p1_ack(o_p1_ack), .o_p1_err(o_p1_err), .o_p1_rdata(o_p1_rdata),
        .o_cpu_stall(o_cpu_stall), .o_mem_en(o_mem_en), .o_mem_wr(o_mem_wr),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [31:0] emem [logic [31:0]];  // environment memory, written by DUT strobes
    logic [31:0] rmem [logic [31:0]];  // reference memory, written by the model

    bit          pend_v = 1'b0;
    int          pend_c;
    logic [31:0] pend_a;

    bit          m_busy = 1'b0;
    bit          m_port, m_wr, m_err;
    bit          m_last = 1'b1;
    logic [31:0] m_addr, m_wdata;
    int          m_n, m_d;

    function automatic logic [31:0] init_val(logic [31:0] a);
        return {a[15:0] ^ 16'h1234, ~a[15:0]};
    endfunction

    task automatic chk1(string name, logic got, logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, got, exp);
        end
    endtask

    task automatic chk32(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // Expected outputs follow from the accept cycle N of the current transaction:
    // issue at N+1, ack at N+1 (misaligned), N+2 (store) or N+LAT+2 (load).
    task automatic model_step();
        logic [1:0]  e_ack, e_err;
        logic [31:0] e_rd0, e_rd1, rv;
        logic        e_en, e_wr;
        logic [31:0] e_addr, e_wd;
        bit          sel;
        e_ack = '0; e_err = '0; e_rd0 = '0; e_rd1 = '0;
        e_en = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
        if (m_busy) begin
            if (!m_err && cyc == m_n + 1) begin
                e_en = 1'b1; e_wr = m_wr; e_addr = m_addr; e_wd = m_wdata;
                if (m_wr) rmem[m_addr] = m_wdata;
            end
            if (cyc == m_d) begin
                rv = '0;
                if (!m_wr && !m_err) rv = rmem.exists(m_addr) ? rmem[m_addr] : init_val(m_addr);
                e_ack[m_port] = 1'b1;
                e_err[m_port] = m_err;
                if (m_port) e_rd1 = rv; else e_rd0 = rv;
            end
        end
        chk1("p0_ack", o_p0_ack, e_ack[0]);
        chk1("p1_ack", o_p1_ack, e_ack[1]);
        chk1("p0_err", o_p0_err, e_err[0]);
        chk1("p1_err", o_p1_err, e_err[1]);
        chk32("p0_rdata", o_p0_rdata, e_rd0);
        chk32("p1_rdata", o_p1_rdata, e_rd1);
        chk1("mem_en", o_mem_en, e_en);
        chk1("cpu_stall", o_cpu_stall, i_p0_req & ~e_ack[0]);
        if (e_en) begin
            chk1("mem_wr", o_mem_wr, e_wr);
            chk32("mem_addr", o_mem_addr, e_addr);
            chk32("mem_wdata", o_mem_wdata, e_wd);
        end
        if (o_mem_en && o_mem_wr) emem[o_mem_addr] = o_mem_wdata;
        if (o_mem_en && !o_mem_wr) begin pend_v = 1'b1; pend_c = cyc; pend_a = o_mem_addr; end
        if (!i_reset) begin
            m_busy = 1'b0; m_last = 1'b1;
        end else if (m_busy) begin
            if (cyc == m_d) begin m_busy = 1'b0; m_last = m_port; end
        end else if (i_p0_req || i_p1_req) begin
`ifdef DMEM_ARB_CPU_PRIORITY_EN
            sel = !i_p0_req;
`else
            sel = (i_p0_req && i_p1_req) ? !m_last : i_p1_req;
`endif
            m_port  = sel;
            m_wr    = sel ? i_p1_wr : i_p0_wr;
            m_addr  = sel ? i_p1_addr : i_p0_addr;
            m_wdata = sel ? i_p1_wdata : i_p0_wdata;
            m_err   = (m_addr[1:0] != 2'b00);
            m_n     = cyc;
            m_d     = m_err ? cyc + 1 : (m_wr ? cyc + 2 : cyc + LAT + 2);
            m_busy  = 1'b1;
        end
    endtask

    // Memory returns valid data only in the cycle LAT after the issue cycle.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (pend_v && cyc == pend_c + LAT) begin
            i_mem_rdata = emem.exists(pend_a) ? emem[pend_a] : init_val(pend_a);
            pend_v = 1'b0;
        end else begin
            i_mem_rdata = $urandom;
        end
    endtask

    task automatic look();
        @(negedge clk);
        model_step();
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        look(); step();
        i_reset = 1'b1;
    endtask

    task automatic wait_ack(input bit port, output int k);
        k = -1;
        for (int i = 0; i < 64; i++) begin
            look();
            if (port ? o_p1_ack : o_p0_ack) begin k = i; return; end
            step();
        end
    endtask

    task automatic rand_fields(output logic wr, output logic [31:0] addr, output logic [31:0] wd);
        wr   = ($urandom_range(0, 1) == 1);
        addr = 32'($urandom_range(0, 15)) << 2;
        if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
        wd   = $urandom;
    endtask

    initial begin
        int k, got, en_cnt;
        int ord [4];
        int exp_ord [4];
        logic a0, a1;
        i_reset = 1'b0;
        i_p0_req = 1'b0; i_p0_wr = 1'b0; i_p0_addr = '0; i_p0_wdata = '0;
        i_p1_req = 1'b0; i_p1_wr = 1'b0; i_p1_addr = '0; i_p1_wdata = '0;
        i_mem_rdata = '0;
        step();

        // reset values; stall follows p0_req even in reset
        i_p0_req = 1'b1;
        look();
        chk1("rst_mem_en", o_mem_en, 1'b0);
        chk1("rst_mem_wr", o_mem_wr, 1'b0);
        chk32("rst_mem_addr", o_mem_addr, 32'h0);
        chk32("rst_mem_wdata", o_mem_wdata, 32'h0);
        chk1("rst_acks", o_p0_ack | o_p1_ack, 1'b0);
        chk1("rst_errs", o_p0_err | o_p1_err, 1'b0);
        chk32("rst_rdata", o_p0_rdata | o_p1_rdata, 32'h0);
        chk1("rst_stall", o_cpu_stall, 1'b1);
        step();
        i_p0_req = 1'b0; i_reset = 1'b1;
        look(); step();

        // CPU store
        i_p0_req = 1'b1; i_p0_wr = 1'b1; i_p0_addr = 32'h100; i_p0_wdata = 32'hDEADBEEF;
        look();
        chk1("st_N_stall", o_cpu_stall, 1'b1);
        chk1("st_N_en", o_mem_en, 1'b0);
        step(); look();
        chk1("st_N1_en", o_mem_en, 1'b1);
        chk1("st_N1_wr", o_mem_wr, 1'b1);
        chk32("st_N1_addr", o_mem_addr, 32'h100);
        chk32("st_N1_wdata", o_mem_wdata, 32'hDEADBEEF);
        chk1("st_N1_stall", o_cpu_stall, 1'b1);
        step(); look();
        chk1("st_N2_ack", o_p0_ack, 1'b1);
        chk1("st_N2_stall", o_cpu_stall, 1'b0);
        step(); i_p0_req = 1'b0;
        look(); step();

        // CPU load of the stored word
        i_p0_req = 1'b1; i_p0_wr = 1'b0; i_p0_addr = 32'h100;
        wait_ack(1'b0, k);
        chk32("ld_latency", k, 32'd5);
        chk32("ld_rdata", o_p0_rdata, 32'hDEADBEEF);
        chk1("ld_p1_ack", o_p1_ack, 1'b0);
        chk32("ld_p1_rdata", o_p1_rdata, 32'h0);
        step(); i_p0_req = 1'b0;
        look(); step();

        // both ports contend continuously
        do_reset();
`ifdef DMEM_ARB_CPU_PRIORITY_EN
        exp_ord = '{0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 0, 1};
`endif
        i_p0_req = 1'b1; i_p0_wr = 1'b0; i_p0_addr = 32'h10;
        i_p1_req = 1'b1; i_p1_wr = 1'b0; i_p1_addr = 32'h20;
        got = 0;
        for (int i = 0; i < 100 && got < 4; i++) begin
            look();
            if (o_p0_ack) begin ord[got] = 0; got++; end
            else if (o_p1_ack) begin ord[got] = 1; got++; end
            step();
        end
        chk32("rr_count", got, 32'd4);
        for (int i = 0; i < 4; i++) chk32("rr_order", (i < got) ? ord[i] : -1, exp_ord[i]);
        i_p0_req = 1'b0; i_p1_req = 1'b0;
        look(); step();

        // misaligned p1 load
        i_p1_req = 1'b1; i_p1_wr = 1'b0; i_p1_addr = 32'h102;
        k = -1; en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            look();
            if (o_mem_en) en_cnt++;
            if (o_p1_ack) begin k = i; chk1("mis_err", o_p1_err, 1'b1); break; end
            step();
        end
        chk32("mis_latency", k, 32'd1);
        chk32("mis_mem_en", en_cnt, 32'd0);
        step(); i_p1_req = 1'b0;
        look(); step();

        // reset during WAIT of a p1 load; p0 pending wins afterwards
        do_reset();
        i_p1_req = 1'b1; i_p1_wr = 1'b0; i_p1_addr = 32'h200;
        look(); step();
        i_p0_req = 1'b1; i_p0_wr = 1'b0; i_p0_addr = 32'h300;
        look(); step();
        look(); step();
        i_reset = 1'b0;
        look();
        chk1("rw_no_ack", o_p1_ack, 1'b0);
        step();
        i_reset = 1'b1;
        look();
        chk1("rw_idle_p0_ack", o_p0_ack, 1'b0);
        chk1("rw_idle_p1_ack", o_p1_ack, 1'b0);
        chk1("rw_idle_en", o_mem_en, 1'b0);
        chk32("rw_idle_addr", o_mem_addr, 32'h0);
        chk1("rw_idle_stall", o_cpu_stall, 1'b1);
        step();
        k = -1;
        for (int i = 0; i < 40; i++) begin
            look();
            if (o_p0_ack) begin k = 0; break; end
            if (o_p1_ack) begin k = 1; break; end
            step();
        end
        chk32("rw_first_port", k, 32'd0);
        step(); i_p0_req = 1'b0;
        wait_ack(1'b1, k);
        chk1("rw_p1_served", (k >= 0), 1'b1);
        step(); i_p1_req = 1'b0;
        look(); step();

        // p0 drops req one cycle after grant
        i_p0_req = 1'b1; i_p0_wr = 1'b0; i_p0_addr = 32'h40;
        look(); step();
        i_p0_req = 1'b0;
        k = -1; en_cnt = 0;
        for (int i = 1; i < 20; i++) begin
            look();
            if (o_mem_en) en_cnt++;
            if (o_p0_ack) begin k = i; break; end
            step();
        end
        chk32("drop_latency", k, 32'd5);
        chk32("drop_en_pulses", en_cnt, 32'd1);
        chk32("drop_rdata", o_p0_rdata, init_val(32'h40));
        step(); look(); step();

        // randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            look();
            a0 = o_p0_ack; a1 = o_p1_ack;
            step();
            i_reset = ($urandom_range(0, 299) != 0);
            if (!i_p0_req || a0) begin
                i_p0_req = ($urandom_range(0, 1) == 1);
                rand_fields(i_p0_wr, i_p0_addr, i_p0_wdata);
            end
            if (!i_p1_req || a1) begin
                i_p1_req = ($urandom_range(0, 1) == 1);
                rand_fields(i_p1_wr, i_p1_addr, i_p1_wdata);
            end
        end
        look();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single data-memory/memory-mapped-I/O port of the processor. It shares that port between the CPU load/store path (port 0) and a debug/loader requester (port 1). Each transaction runs through a small FSM: arbitrate, issue one memory cycle, wait for the configured read latency, acknowledge. It also drives a stall signal that holds the PC while a CPU access is outstanding.

## Interface
- DBITS, 32, data and address width
- MEM_LATENCY, 1, read-data latency of the memory in cycles after the issue cycle; legal range 1..15
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  one clock; reset is synchronous and active-low
- p0_req, p1_req  in  1  request; each requester holds its request and fields stable until its ack
- p0_wr, p1_wr  in  1  1 = store, 0 = load
- p0_addr, p1_addr  in  DBITS  byte address; must be word aligned
- p0_wdata, p1_wdata  in  DBITS  store data
- p0_ack, p1_ack  out  1  one-cycle completion pulse
- p0_err, p1_err  out  1  qualifies ack: misaligned address, no memory access performed
- p0_rdata, p1_rdata  out  DBITS  load data, valid while ack is high
- cpu_stall  out  1  p0_req & ~p0_ack, combinational
- mem_en  out  1  one-cycle memory strobe
- mem_wr  out  1  write enable, qualified by mem_en
- mem_addr, mem_wdata  out  DBITS  selected requester's fields
- mem_rdata  in  DBITS  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Reset forces IDLE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requesting: round-robin. The port not granted last wins. The last-grant pointer resets to port 1, so the CPU wins the first contest.
  - On a grant, latch the grant index, wr, addr and wdata into internal registers, then go to ISSUE.
- Misaligned address (addr[1:0] != 0) at grant: skip ISSUE and go directly to DONE with err=1. mem_en stays low.
- ISSUE:
  - mem_en=1 and mem_wr=latched wr; mem_addr and mem_wdata come from the latched fields.
  - Store: go to DONE.
  - Load: load the latency counter with MEM_LATENCY and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture mem_rdata into the read register and go to DONE.
- DONE:
  - Pulse ack and err on the granted port only; rdata is the captured value (0 for stores and errors).
  - Update the last-grant pointer, then return to IDLE.
- Non-granted port: ack, err and rdata all 0.
- Requester deasserts req mid-transaction: protocol violation. The transaction still completes and ack still pulses.
- Reset mid-transaction:
  - Abort immediately; the next cycle is IDLE with all outputs at reset values.
  - Any memory write already issued stands.
- Reset values: mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, both ack=0, both err=0, both rdata=0. cpu_stall follows p0_req.

## Timing
- All latencies are counted from the cycle N in which req is first seen in IDLE.
- Store: mem_en in N+1, ack in N+2.
- Load: mem_en in N+1, mem_rdata sampled at the end of N+MEM_LATENCY+1, ack with rdata in N+MEM_LATENCY+2.
- Misaligned access: ack with err=1 in N+1.
- A new request is accepted in the cycle after DONE. Back-to-back stores therefore take 3 cycles each, and loads take MEM_LATENCY+3.
- A waiting port is served within one transaction time of the other port (starvation-free under round-robin).

## Configuration
- DMEM_ARB_CPU_PRIORITY_EN defined:
  - Fixed priority; port 0 always wins simultaneous requests.
  - The last-grant pointer is not implemented.
  - Port 1 can starve while p0_req is held.
- Undefined: round-robin as described under Operation.

## Test plan
- Single CPU store, addr 0x100, wdata 0xDEADBEEF, MEM_LATENCY=1 -> mem_en/mem_wr in N+1 with those fields; p0_ack in N+2; cpu_stall high in N..N+1 and low in N+2.
- CPU load from 0x100 with memory model returning 0xDEADBEEF, MEM_LATENCY=3 -> p0_ack in N+5, p0_rdata=0xDEADBEEF, p1 outputs 0.
- Both ports request loads at the same cycle and keep re-requesting -> grants P0, P1, P0, P1; with DMEM_ARB_CPU_PRIORITY_EN, P0 is granted every time and p1_ack never pulses.
- p1 load from misaligned addr 0x102 -> p1_ack=1 and p1_err=1 in N+1, mem_en never asserted.
- reset low during WAIT of a p1 load -> next cycle IDLE, no ack, all outputs 0; pending p0_req granted first after reset releases.
- p0_req dropped one cycle after grant -> transaction completes, mem_en pulses once, p0_ack pulses at nominal time.
